// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: scan codes, receive
// states and the btns bit layout used by the game logic.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the keyboard pins, finds falling clock
// edges and assembles 11-bit frames into bytes, dropping bad or stalled frames.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int WdW = $clog2(TIMEOUT_CYCLES + 1);
  typedef logic [WdW-1:0] wd_t;
  localparam wd_t WdMax = wd_t'(TIMEOUT_CYCLES);

  logic      clk_meta_q, clk_sync_q, clk_prev_q;
  logic      data_meta_q, data_sync_q;
  logic      fall;
  rx_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic      par_q, par_d;
  wd_t       wd_q, wd_d;
  logic      vld_q, vld_d;
  logic      err_q, err_d;

  assign fall = clk_prev_q & ~clk_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      wd_q        <= '0;
      vld_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      wd_q        <= wd_d;
      vld_q       <= vld_d;
      err_q       <= err_d;
    end
  end

  // A falling edge always takes priority over an expiring watchdog.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    wd_d    = wd_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    if (fall || state_q == IDLE) begin
      wd_d = '0;
    end else if (wd_q != WdMax) begin
      wd_d = wd_q + wd_t'(1);
    end

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_sync_q) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {data_sync_q, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_sync_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_sync_q && ^{shift_q, par_q}) vld_d = 1'b1;
          else                                  err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && wd_q == WdMax) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  assign byte_o      = shift_q;
  assign byte_vld_o  = vld_q;
  assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 scan codes into the game's held arrow buttons and one-shot
// continue/start pulses, ignoring keyboard auto-repeat for the pulses.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [3:0] btns,
  output logic       continue_btn,
  output logic       start_btn,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [3:0] btns_q, btns_d;
  logic       space_held_q, space_held_d, enter_held_q, enter_held_d;
  logic       cont_q, cont_d, start_q, start_d;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i      (clk),
    .rst_ni     (rst),
    .ps2_clk_i  (PS2_CLK),
    .ps2_data_i (PS2_DATA),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .frame_err_o(rx_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      btns_q       <= '0;
      space_held_q <= 1'b0;
      enter_held_q <= 1'b0;
      cont_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      btns_q       <= btns_d;
      space_held_q <= space_held_d;
      enter_held_q <= enter_held_d;
      cont_q       <= cont_d;
      start_q      <= start_d;
    end
  end

  // Prefix bytes only arm flags; the next ordinary byte consumes them.
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    btns_d       = btns_q;
    space_held_d = space_held_q;
    enter_held_d = enter_held_q;
    cont_d       = 1'b0;
    start_d      = 1'b0;

    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_vld) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (ext_q) begin
          case (rx_byte)
            SC_UP:    btns_d[BTN_UP]    = ~brk_q;
            SC_DOWN:  btns_d[BTN_DOWN]  = ~brk_q;
            SC_LEFT:  btns_d[BTN_LEFT]  = ~brk_q;
            SC_RIGHT: btns_d[BTN_RIGHT] = ~brk_q;
            default: ;
          endcase
        end else begin
          case (rx_byte)
            SC_SPACE: begin
              cont_d       = ~brk_q & ~space_held_q;
              space_held_d = ~brk_q;
            end
            SC_ENTER: begin
              start_d      = ~brk_q & ~enter_held_q;
              enter_held_d = ~brk_q;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign btns         = btns_q;
  assign continue_btn = cont_q;
  assign start_btn    = start_q;
  assign frame_err    = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: drives PS/2 frames on the pins and
// matches every output pulse against a queue of expected events.
module tb_ps2_key_decoder;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 20;
  localparam int EV_CONT  = 1;
  localparam int EV_START = 2;
  localparam int EV_ERR   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [3:0] btns;
  logic       continue_btn, start_btn, frame_err;

  int checks = 0;
  int failures = 0;
  int expQ[$];
  logic [3:0] btnsExp = 4'b0000;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .PS2_CLK     (PS2_CLK),
    .PS2_DATA    (PS2_DATA),
    .btns        (btns),
    .continue_btn(continue_btn),
    .start_btn   (start_btn),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic popEvent(input int ev);
    if (expQ.size() == 0) checkOutput("unexpected_event", ev, 0);
    else checkOutput("event", ev, expQ.pop_front());
  endtask

  // Every high cycle of a pulse is a separate event, so wide pulses show up as extras.
  always @(negedge clk) begin
    if (rst) begin
      if (continue_btn) popEvent(EV_CONT);
      if (start_btn)    popEvent(EV_START);
      if (frame_err)    popEvent(EV_ERR);
    end
  end

  task automatic ps2Bit(input logic b);
    PS2_DATA = b;
    repeat (HALF) @(posedge clk);
    PS2_CLK = 1'b0;
    repeat (HALF) @(posedge clk);
    PS2_CLK = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic badParity = 1'b0);
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit(badParity ? ^b : ~^b);
    ps2Bit(1'b1);
    PS2_DATA = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic settleAndCheck(input string tag);
    repeat (20) @(posedge clk);
    #1;
    checkOutput({tag, "_btns"}, int'(btns), int'(btnsExp));
    checkOutput({tag, "_pending"}, expQ.size(), 0);
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_btns", int'(btns), 0);
    checkOutput("reset_cont", int'(continue_btn), 0);
    checkOutput("reset_start", int'(start_btn), 0);
    checkOutput("reset_err", int'(frame_err), 0);
    rst = 1'b1;
    repeat (10) @(posedge clk);

    // Arrow make and break
    applyStimulus(8'hE0); applyStimulus(8'h75);
    btnsExp = 4'b1000; settleAndCheck("up_make");
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    btnsExp = 4'b0000; settleAndCheck("up_break");

    // Typematic repeat on space, then enter
    expQ.push_back(EV_CONT);
    applyStimulus(8'h29); applyStimulus(8'h29); applyStimulus(8'h29);
    applyStimulus(8'hF0); applyStimulus(8'h29);
    settleAndCheck("space_repeat");
    expQ.push_back(EV_START);
    applyStimulus(8'h5A);
    settleAndCheck("enter");

    // Parity error then valid space
    expQ.push_back(EV_ERR);
    applyStimulus(8'h29, 1'b1);
    settleAndCheck("parity_err");
    expQ.push_back(EV_CONT);
    applyStimulus(8'h29);
    settleAndCheck("space_after_err");

    // Watchdog abandons a stalled frame
    expQ.push_back(EV_ERR);
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(1'b1);
    repeat (TIMEOUT + 10) @(posedge clk);
    settleAndCheck("timeout");
    applyStimulus(8'hE0); applyStimulus(8'h6B);
    btnsExp = 4'b0010; settleAndCheck("left_make");
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h6B);
    btnsExp = 4'b0000; settleAndCheck("left_break");

    // Combined hold with an unmapped code and an arrow repeat
    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'h1C);
    btnsExp = 4'b1000; settleAndCheck("unmapped");
    applyStimulus(8'hE0); applyStimulus(8'h74);
    btnsExp = 4'b1001; settleAndCheck("combined");
    applyStimulus(8'hE0); applyStimulus(8'h74);
    settleAndCheck("right_repeat");
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    btnsExp = 4'b0001; settleAndCheck("up_release");
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h74);
    applyStimulus(8'hE0); applyStimulus(8'h72);
    btnsExp = 4'b0100; settleAndCheck("down_make");

    // Reset mid-frame while down is held
    ps2Bit(1'b0); ps2Bit(1'b1); ps2Bit(1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_btns", int'(btns), 0);
    checkOutput("rst_cont", int'(continue_btn), 0);
    checkOutput("rst_start", int'(start_btn), 0);
    checkOutput("rst_err", int'(frame_err), 0);
    btnsExp = 4'b0000;
    PS2_CLK = 1'b1; PS2_DATA = 1'b1;
    repeat (10) @(posedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    expQ.push_back(EV_CONT);
    applyStimulus(8'h29);
    settleAndCheck("space_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 keyboard frames from the board pins and turns them into the game's player-control signals: four held direction buttons, a continue pulse and a start pulse. It sits directly upstream of the top-level game. `btns` drives the player object, the scroll and obstacle blocks, and the audio select decoder. `continue_btn` and `start_btn` drive the game FSM and the colour counter.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: clk cycles without a PS/2 falling edge after which a partial frame is abandoned (1 ms at 100 MHz).

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: reset, asynchronous, active-low. All state clears while low.
- `PS2_CLK`, in, 1: raw keyboard clock, asynchronous to `clk`.
- `PS2_DATA`, in, 1: raw keyboard data, asynchronous to `clk`.
- `btns`, out, 4: held state of the arrow keys; [3]=up, [2]=down, [1]=left, [0]=right.
- `continue_btn`, out, 1: one-cycle pulse on a space make event.
- `start_btn`, out, 1: one-cycle pulse on an enter make event.
- `frame_err`, out, 1: one-cycle pulse when a frame is discarded.

## Operation
- **Input path:** `PS2_CLK` and `PS2_DATA` each pass through a 2-flop synchronizer. A third register on the clock line gives the falling-edge strobe `fall` = previous & ~current. `PS2_DATA` is sampled only on `fall`.
- **Receive FSM:**
  - IDLE: on `fall` with data=0 (start bit), go to DATA with bit count 0. On `fall` with data=1, stay in IDLE with no error.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: if the stop bit = 1 and the 9 bits (data plus parity) have odd parity, assert `byte_vld` with `byte`. Otherwise pulse `frame_err`. Return to IDLE in both cases.
- **Watchdog:** a counter clears on every `fall` and counts while the receive FSM is outside IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE and `frame_err` pulses. The counter saturates; it never wraps.
- **Decode stage:** consumes `byte_vld`. Holds two flags, `ext` and `brk`.
  - Byte 0xE0: set `ext`.
  - Byte 0xF0: set `brk`.
  - Any other byte: decode it using the current flags, then clear both flags.
  - The flags are also cleared by `frame_err`.
- **Key map:**

  | Prefix | Code | Key | Output |
  |---|---|---|---|
  | ext=1 | 0x75 | up | `btns[3]` |
  | ext=1 | 0x72 | down | `btns[2]` |
  | ext=1 | 0x6B | left | `btns[1]` |
  | ext=1 | 0x74 | right | `btns[0]` |
  | ext=0 | 0x29 | space | continue |
  | ext=0 | 0x5A | enter | start |

  - Arrow keys: a make sets the `btns` bit and a break clears it.
  - Any other code is ignored and leaves all outputs unchanged.
- **Typematic suppression:** internal held flags track space and enter. A pulse fires only on a make while the key's held flag is 0. The make sets the flag and a break clears it. Repeated makes from key auto-repeat therefore produce exactly one pulse.
- **Arrow repeats:** a repeated arrow make rewrites 1 to the bit, so `btns` stays level and does not change.

## Timing
- **Reset values:** `btns`=0000, `continue_btn`=0, `start_btn`=0, `frame_err`=0. The FSM is in IDLE, the flags are 0 and the watchdog is 0.
- **Edge detection:** `fall` asserts 3 clk cycles after the pin edge (two synchronizer flops plus the edge register).
- **Byte and error timing:** `byte_vld` and `frame_err` assert in the cycle after the `fall` that samples the stop bit.
- **Output timing:**
  - `btns` updates 1 cycle after `byte_vld`.
  - `continue_btn` and `start_btn` go high 1 cycle after `byte_vld` and stay high for exactly 1 cycle.
- **Simultaneous timeout and edge:** if the watchdog reaches its limit in the same cycle as a `fall`, the `fall` wins. The watchdog clears and the bit is taken.
- **Reset mid-frame:** the partial frame is dropped and no output pulses. Decoding resumes from the next start bit after `rst` returns high.
- **Output registers:** all outputs are registered and there is no combinational path from pin to output.
- **Rate:** at most one decoded key per byte. The design sustains the PS/2 rate (≤16.7 kHz) with large margin.

## Structure
- **Shared package `ps2_pkg`:**
  - Scan-code constants: `SC_EXT`=0xE0, `SC_BRK`=0xF0, `SC_UP`, `SC_DOWN`, `SC_LEFT`, `SC_RIGHT`, `SC_SPACE`, `SC_ENTER`.
  - Receive state enum: IDLE, DATA, PARITY, STOP.
  - `btns` bit-index constants.
- **Sub-module `ps2_rx_frame`:** contains the synchronizer, edge detector, receive FSM and watchdog, and outputs `byte`, `byte_vld` and `frame_err`.
- **Top module `ps2_key_decoder`:** contains the prefix flags, the key map and the pulse logic.

## Test plan
- **Arrow make and break:** send frames E0,75 → `btns`=1000. Then send E0,F0,75 → `btns`=0000. No `frame_err`.
- **Typematic repeat:** send 29, 29, 29 then F0,29 → `continue_btn` pulses exactly once, 1 cycle wide. Then send 5A → `start_btn` pulses once.
- **Parity error:** send 0x29 with even parity → `frame_err` pulses once, `continue_btn` stays 0. A following valid 29 then pulses normally.
- **Timeout:** stop `PS2_CLK` after 4 data bits for `TIMEOUT_CYCLES`+10 cycles → `frame_err` pulses once. Then send E0,6B → `btns`=0010.
- **Combined hold:** send E0,75 then E0,74 → `btns`=1001. Then send E0,F0,75 → `btns`=0001. An unmapped code 0x1C in between leaves `btns` unchanged.
- **Reset mid-frame:** drive `rst` low mid-frame while `btns`=0100 → all outputs are 0 immediately (asynchronous). After release, a fresh 29 pulses `continue_btn`.
